// File: rtl/bus_xfer_pkg.sv
// ============================================================================
// Module   : bus_xfer_pkg
// Brief    : Shared bus source/destination encodings, FSM states and helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_xfer_pkg;

    localparam logic [3:0] SRC_PC = 4'd0;
    localparam logic [3:0] SRC_AR = 4'd1;
    localparam logic [3:0] SRC_AC = 4'd2;
    localparam logic [3:0] SRC_R  = 4'd3;
    localparam logic [3:0] SRC_DM = 4'd4;
    localparam logic [3:0] SRC_IM = 4'd5;
    localparam logic [3:0] SRC_DR = 4'd6;
    localparam logic [3:0] SRC_A  = 4'd7;
    localparam logic [3:0] SRC_B  = 4'd8;
    localparam logic [3:0] SRC_C  = 4'd9;

    localparam int DST_PC = 0;
    localparam int DST_AR = 1;
    localparam int DST_AC = 2;
    localparam int DST_R  = 3;
    localparam int DST_DM = 4;
    localparam int DST_IM = 5;
    localparam int DST_DR = 6;
    localparam int DST_A  = 7;
    localparam int DST_B  = 8;
    localparam int DST_C  = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } xfer_state_t;

    function automatic logic is_mem_src(input logic [3:0] src);
        return (src == SRC_DM) || (src == SRC_IM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_src_decode.sv
// ============================================================================
// Module   : bus_src_decode
// Brief    : Source index to one-hot decoder with an in-range flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_src_decode #(
    parameter int N     = 10,
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot,
    output logic             valid
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = (idx == IDX_W'(i));
        end
    end

    assign valid = (int'(idx) < N);

endmodule

`default_nettype wire

// File: rtl/bus_xfer_ctrl.sv
// ============================================================================
// Module   : bus_xfer_ctrl
// Brief    : Bus transfer sequencer: source drive, memory stretch, dest load.
//            Optional BUS_XFER_CAPTURE_EN adds the xfer_data trace register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int N_SRC    = 10,
    parameter int N_DST    = 10,
    parameter int MEM_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_src,
    input  logic [N_DST-1:0]  req_dst,
    input  logic [DATA_W-1:0] bus,
    output logic [N_SRC-1:0]  src_read_en,
    output logic [N_DST-1:0]  dst_write_en,
    output logic              done,
    output logic              err
`ifdef BUS_XFER_CAPTURE_EN
    ,
    output logic [DATA_W-1:0] xfer_data
`endif
);

    localparam logic [2:0] C_WAIT_LOAD = (MEM_WAIT > 0) ? 3'(MEM_WAIT - 1) : 3'd0;
    localparam logic       C_MEM_STRETCH = (MEM_WAIT > 0);

    xfer_state_t       r_state;
    xfer_state_t       w_next;
    logic [3:0]        r_src;
    logic [N_SRC-1:0]  r_src_oh;
    logic [N_DST-1:0]  r_dst;
    logic [2:0]        r_wait_cnt;
    logic [N_SRC-1:0]  w_req_oh;
    logic              w_req_src_ok;
    logic              w_accept;

    bus_src_decode #(
        .N     (N_SRC),
        .IDX_W (4)
    ) u_src_decode (
        .idx    (req_src),
        .onehot (w_req_oh),
        .valid  (w_req_src_ok)
    );

    assign w_accept = req_valid && (r_state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_src      <= '0;
            r_src_oh   <= '0;
            r_dst      <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_src    <= req_src;
                r_src_oh <= w_req_oh;
                r_dst    <= req_dst;
            end
            if (r_state == ST_DRIVE) begin
                r_wait_cnt <= C_WAIT_LOAD;
            end else if (r_state == ST_WAIT && r_wait_cnt != 3'd0) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end
        end
    end

    // Outputs decode only registered state, so reset clears them immediately.
    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        src_read_en  = '0;
        dst_write_en = '0;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_next = (!w_req_src_ok || req_dst == '0) ? ST_ERR : ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                src_read_en = r_src_oh;
                w_next = (is_mem_src(r_src) && C_MEM_STRETCH) ? ST_WAIT : ST_WRITE;
            end
            ST_WAIT: begin
                src_read_en = r_src_oh;
                if (r_wait_cnt == 3'd0) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                src_read_en  = r_src_oh;
                dst_write_en = r_dst;
                done         = 1'b1;
                w_next       = ST_IDLE;
            end
            ST_ERR: begin
                err    = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

`ifdef BUS_XFER_CAPTURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_data <= '0;
        end else if (r_state == ST_WRITE) begin
            xfer_data <= bus;
        end
    end
`else
    logic w_bus_unused;
    assign w_bus_unused = ^bus;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_xfer_ctrl.sv
// ============================================================================
// Module   : tb_bus_xfer_ctrl
// Brief    : Directed self-checking bench for bus_xfer_ctrl (MEM_WAIT=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_src = '0;
    logic [9:0]  req_dst = '0;
    logic [15:0] bus = '0;
    logic [9:0]  src_read_en;
    logic [9:0]  dst_write_en;
    logic        done;
    logic        err;
`ifdef BUS_XFER_CAPTURE_EN
    logic [15:0] xfer_data;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_xfer_ctrl #(
        .DATA_W   (16),
        .N_SRC    (10),
        .N_DST    (10),
        .MEM_WAIT (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_src      (req_src),
        .req_dst      (req_dst),
        .bus          (bus),
        .src_read_en  (src_read_en),
        .dst_write_en (dst_write_en),
        .done         (done),
        .err          (err)
`ifdef BUS_XFER_CAPTURE_EN
        ,
        .xfer_data    (xfer_data)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] src, input logic [9:0] dst);
        req_src   = src;
        req_dst   = dst;
        req_valid = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic [9:0] s, input logic [9:0] d,
                           input logic dn, input logic er, input logic rdy);
        chk({tag, ".src"},   32'(src_read_en),  32'(s));
        chk({tag, ".dst"},   32'(dst_write_en), 32'(d));
        chk({tag, ".done"},  32'(done),         32'(dn));
        chk({tag, ".err"},   32'(err),          32'(er));
        chk({tag, ".ready"}, 32'(req_ready),    32'(rdy));
    endtask

    initial begin
        // Reset state
        #2;
        chk_out("reset", 10'h000, 10'h000, 1'b0, 1'b0, 1'b1);
`ifdef BUS_XFER_CAPTURE_EN
        chk("reset.xfer_data", 32'(xfer_data), 32'h0);
`endif
        step();
        rst = 1'b0;
        step();

        // AC -> A register transfer
        issue(4'd2, 10'h080);
        step();
        req_valid = 1'b0;
        chk_out("ac.c1", 10'h004, 10'h000, 1'b0, 1'b0, 1'b0);
        bus = 16'hBEEF;
        step();
        chk_out("ac.c2", 10'h004, 10'h080, 1'b1, 1'b0, 1'b0);
        step();
        bus = 16'h1234;
        chk_out("ac.c3", 10'h000, 10'h000, 1'b0, 1'b0, 1'b1);
`ifdef BUS_XFER_CAPTURE_EN
        chk("cap.after_write", 32'(xfer_data), 32'hBEEF);
        step();
        step();
        chk("cap.held", 32'(xfer_data), 32'hBEEF);
`endif

        // DM -> DR memory transfer with one wait cycle
        issue(4'd4, 10'h040);
        step();
        req_valid = 1'b0;
        chk_out("dm.c1", 10'h010, 10'h000, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("dm.c2", 10'h010, 10'h000, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("dm.c3", 10'h010, 10'h040, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("dm.c4", 10'h000, 10'h000, 1'b0, 1'b0, 1'b1);

        // Out-of-range source
        issue(4'd12, 10'h001);
        step();
        req_valid = 1'b0;
        chk_out("badsrc.c1", 10'h000, 10'h000, 1'b0, 1'b1, 1'b0);
        step();
        chk_out("badsrc.c2", 10'h000, 10'h000, 1'b0, 1'b0, 1'b1);

        // Empty destination mask
        issue(4'd3, 10'h000);
        step();
        req_valid = 1'b0;
        chk_out("nodst.c1", 10'h000, 10'h000, 1'b0, 1'b1, 1'b0);
        step();
        chk_out("nodst.c2", 10'h000, 10'h000, 1'b0, 1'b0, 1'b1);

        // req_valid held with changing fields: second request waits for IDLE
        issue(4'd7, 10'h100);
        step();
        issue(4'd8, 10'h001);
        chk_out("hold.c1", 10'h080, 10'h000, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("hold.c2", 10'h080, 10'h100, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("hold.c3", 10'h000, 10'h000, 1'b0, 1'b0, 1'b1);
        step();
        req_valid = 1'b0;
        chk_out("hold.c4", 10'h100, 10'h000, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("hold.c5", 10'h100, 10'h001, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("hold.c6", 10'h000, 10'h000, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset during WAIT abandons the transfer
        issue(4'd4, 10'h008);
        step();
        req_valid = 1'b0;
        step();
        chk_out("rstwait.c2", 10'h010, 10'h000, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_out("rstwait.async", 10'h000, 10'h000, 1'b0, 1'b0, 1'b1);
        step();
        #3;
        rst = 1'b0;
        step();
        chk_out("rstwait.after", 10'h000, 10'h000, 1'b0, 1'b0, 1'b1);
        step();
        chk_out("rstwait.idle", 10'h000, 10'h000, 1'b0, 1'b0, 1'b1);

        // Self-transfer IM -> IM-side load
        issue(4'd5, 10'h020);
        step();
        req_valid = 1'b0;
        chk_out("self.c1", 10'h020, 10'h000, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("self.c2", 10'h020, 10'h000, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("self.c3", 10'h020, 10'h020, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("self.c4", 10'h000, 10'h000, 1'b0, 1'b0, 1'b1);

        // Multi-bit mask from C
        issue(4'd9, 10'h3C1);
        step();
        req_valid = 1'b0;
        chk_out("multi.c1", 10'h200, 10'h000, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("multi.c2", 10'h200, 10'h3C1, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("multi.c3", 10'h000, 10'h000, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
